// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM states,
// default geometry and the canonical detector pattern.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned DEF_GAP_W = 4;

  localparam logic [3:0] PAT_1011 = 4'b1011;

endpackage

// File: rtl/seq_gen_piso_shift.sv
// WIDTH-bit parallel-load, MSB-first shift register; zeros shift in from the
// bottom so the output settles to 0 once a frame has been fully shifted out.
module piso_shift #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign sout = sr[WIDTH-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends a latched WIDTH-bit pattern MSB-first,
// repeated count times with gap zero cycles between frames.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] count,
  input  logic [GAP_W-1:0] gap,
  output logic             signal,
  output logic             busy,
  output logic             frame_end,
  output logic             done
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] frames_left;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_q;
  logic [WIDTH-1:0] pat_q;

  logic             accept;
  logic             sr_load;
  logic             sr_shift;
  logic [WIDTH-1:0] sr_din;

  assign accept = start && (count != '0) && (state == IDLE || state == DONE);

  // The shift register itself is the registered serial output: the final
  // shift of each frame leaves it all-zero for GAP/DONE/IDLE.
  always_comb begin
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_din   = pat_q;
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          sr_load = 1'b1;
          sr_din  = pattern;
        end
      end
      SEND: begin
        if (bit_idx == '0 && frames_left > CNT_W'(1) && gap_q == '0) begin
          sr_load = 1'b1;
        end else begin
          sr_shift = 1'b1;
        end
      end
      GAP: begin
        sr_load = (gap_cnt == GAP_W'(1));
      end
    endcase
  end

  piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .sout  (signal)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      frame_end   <= 1'b0;
      done        <= 1'b0;
      bit_idx     <= '0;
      frames_left <= '0;
      gap_cnt     <= '0;
      gap_q       <= '0;
      pat_q       <= '0;
    end else begin
      frame_end <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (accept) begin
            pat_q       <= pattern;
            gap_q       <= gap;
            frames_left <= count;
            bit_idx     <= IDX_TOP;
            busy        <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (bit_idx != '0) begin
            bit_idx   <= bit_idx - IDX_W'(1);
            frame_end <= (bit_idx == IDX_W'(1));
          end else begin
            frames_left <= frames_left - CNT_W'(1);
            if (frames_left > CNT_W'(1)) begin
              if (gap_q == '0) begin
                bit_idx <= IDX_TOP;
              end else begin
                gap_cnt <= gap_q;
                state   <= GAP;
              end
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            gap_cnt <= '0;
            bit_idx <= IDX_TOP;
            state   <= SEND;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: per-cycle expectations {signal,busy,frame_end,done}
// are queued from a behavioural model and compared as the DUT produces them.
module tb_seq_gen;
  import seq_gen_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] pattern;
  logic [7:0] count;
  logic [3:0] gap;
  logic       signal;
  logic       busy;
  logic       frame_end;
  logic       done;

  int total = 0;
  int bad   = 0;

  logic [3:0] q[$];

  seq_gen #(.WIDTH(4), .CNT_W(8), .GAP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .count     (count),
    .gap       (gap),
    .signal    (signal),
    .busy      (busy),
    .frame_end (frame_end),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Model of one transfer: frames MSB-first, gap zero cycles between frames, then a done cycle.
  task automatic push_transfer(input logic [3:0] p, input int unsigned n, input int unsigned g);
    for (int unsigned f = 0; f < n; f++) begin
      for (int b = 3; b >= 0; b--) begin
        q.push_back({p[b], 1'b1, (b == 0), 1'b0});
      end
      if (f + 1 < n) begin
        for (int unsigned k = 0; k < g; k++) q.push_back(4'b0100);
      end
    end
    q.push_back(4'b0001);
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst = 1'b0; start = 1'b1; pattern = PAT_1011; count = 8'd1; gap = 4'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      obs = {signal, busy, frame_end, done};
      total++;
      if (obs !== 4'b0000) begin
        bad++; $display("FAIL reset_hold cyc=%0d got=%b want=0000", i, obs);
      end
    end
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      obs = {signal, busy, frame_end, done};
      total++;
      if (obs !== 4'b0000) begin
        bad++; $display("FAIL reset_idle cyc=%0d got=%b want=0000", i, obs);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] e, obs;
    int cyc = 0;
    pattern = PAT_1011; count = 8'd1; gap = 4'd0; start = 1'b1;
    push_transfer(PAT_1011, 1, 0);
    q.push_back(4'b0000);
    @(posedge clk); #1; start = 1'b0;
    while (q.size() > 0) begin
      cyc++; e = q.pop_front(); obs = {signal, busy, frame_end, done};
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL single cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e, obs;
    int cyc = 0, det = 0, hits = 0, fe = 0, bz = 0;
    pattern = PAT_1011; count = 8'd3; gap = 4'd0; start = 1'b1;
    push_transfer(PAT_1011, 3, 0);
    q.push_back(4'b0000);
    @(posedge clk); #1; start = 1'b0;
    while (q.size() > 0) begin
      cyc++; e = q.pop_front(); obs = {signal, busy, frame_end, done};
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL b2b cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      fe += int'(frame_end);
      bz += int'(busy);
      case (det)
        0: det = signal ? 1 : 0;
        1: det = signal ? 1 : 2;
        2: det = signal ? 3 : 0;
        default: begin
          if (signal) begin hits++; det = 0; end
          else det = 2;
        end
      endcase
      @(posedge clk); #1;
    end
    total++;
    if (hits !== 3) begin bad++; $display("FAIL b2b_detect got=%0d want=3", hits); end
    total++;
    if (fe !== 3) begin bad++; $display("FAIL b2b_frame_end got=%0d want=3", fe); end
    total++;
    if (bz !== 12) begin bad++; $display("FAIL b2b_busy got=%0d want=12", bz); end
  endtask

  task automatic test_gap();
    logic [3:0] e, obs;
    int cyc = 0, bz = 0;
    pattern = 4'b1101; count = 8'd2; gap = 4'd3; start = 1'b1;
    push_transfer(4'b1101, 2, 3);
    q.push_back(4'b0000);
    @(posedge clk); #1; start = 1'b0;
    while (q.size() > 0) begin
      cyc++; e = q.pop_front(); obs = {signal, busy, frame_end, done};
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL gap cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      bz += int'(busy);
      @(posedge clk); #1;
    end
    total++;
    if (bz !== 11) begin bad++; $display("FAIL gap_busy got=%0d want=11", bz); end
  endtask

  task automatic test_count_zero();
    logic [3:0] e, obs;
    int cyc = 0;
    pattern = PAT_1011; count = 8'd0; gap = 4'd2; start = 1'b1;
    for (int i = 0; i < 4; i++) q.push_back(4'b0000);
    @(posedge clk); #1; start = 1'b0;
    while (q.size() > 0) begin
      cyc++; e = q.pop_front(); obs = {signal, busy, frame_end, done};
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL count_zero cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_midstart();
    logic [3:0] e, obs;
    int cyc = 0;
    pattern = PAT_1011; count = 8'd2; gap = 4'd1; start = 1'b1;
    push_transfer(PAT_1011, 2, 1);
    q.push_back(4'b0000);
    @(posedge clk); #1; start = 1'b0;
    while (q.size() > 0) begin
      cyc++; e = q.pop_front(); obs = {signal, busy, frame_end, done};
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL midstart cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      if (cyc >= 2 && cyc <= 8) begin
        start = 1'b1; pattern = 4'b0000; count = 8'd7; gap = 4'd5;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic test_done_restart();
    logic [3:0] e, obs;
    int cyc = 0;
    bit fired = 1'b0;
    pattern = 4'b1101; count = 8'd1; gap = 4'd0; start = 1'b1;
    push_transfer(4'b1101, 1, 0);
    @(posedge clk); #1; start = 1'b0;
    while (q.size() > 0) begin
      cyc++; e = q.pop_front(); obs = {signal, busy, frame_end, done};
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL done_restart cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      if (e[0] && !fired) begin
        fired = 1'b1;
        start = 1'b1; pattern = PAT_1011; count = 8'd1; gap = 4'd2;
        push_transfer(PAT_1011, 1, 2);
        q.push_back(4'b0000);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic test_abort();
    logic [3:0] e, obs;
    int cyc = 0;
    pattern = PAT_1011; count = 8'd2; gap = 4'd0; start = 1'b1;
    q.push_back(4'b1100); q.push_back(4'b0100); q.push_back(4'b1100);
    for (int i = 0; i < 3; i++) q.push_back(4'b0000);
    @(posedge clk); #1; start = 1'b0;
    while (q.size() > 0) begin
      cyc++; e = q.pop_front(); obs = {signal, busy, frame_end, done};
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL abort cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      if (cyc == 3) rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
    end
    cyc = 0;
    pattern = 4'b0110; count = 8'd2; gap = 4'd1; start = 1'b1;
    push_transfer(4'b0110, 2, 1);
    q.push_back(4'b0000);
    @(posedge clk); #1; start = 1'b0;
    while (q.size() > 0) begin
      cyc++; e = q.pop_front(); obs = {signal, busy, frame_end, done};
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL after_abort cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_limits();
    logic [3:0] e, obs;
    int cyc = 0;
    pattern = 4'b1001; count = 8'd255; gap = 4'd0; start = 1'b1;
    push_transfer(4'b1001, 255, 0);
    q.push_back(4'b0000);
    @(posedge clk); #1; start = 1'b0;
    while (q.size() > 0) begin
      cyc++; e = q.pop_front(); obs = {signal, busy, frame_end, done};
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL max_count cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      @(posedge clk); #1;
    end
    cyc = 0;
    pattern = 4'b0111; count = 8'd2; gap = 4'd15; start = 1'b1;
    push_transfer(4'b0111, 2, 15);
    q.push_back(4'b0000);
    @(posedge clk); #1; start = 1'b0;
    while (q.size() > 0) begin
      cyc++; e = q.pop_front(); obs = {signal, busy, frame_end, done};
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL max_gap cyc=%0d got=%b want=%b", cyc, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pattern = '0; count = '0; gap = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_count_zero();
    test_midstart();
    test_done_restart();
    test_abort();
    test_limits();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern transmitter: on request, emits a programmable WIDTH-bit pattern MSB-first on a single-bit line, repeated a programmed number of times with an optional zero-gap between frames. It is the transmit end of the serial sequence-detector interface. Its `signal` output connects directly to the detector's `signal` input, which makes it both the stimulus source in system benches and a standalone pattern source.

## Interface
- `WIDTH`, default 4: pattern length in bits, ≥ 2.
- `CNT_W`, default 8: width of the frame-count field.
- `GAP_W`, default 4: width of the inter-frame gap field.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: reset, synchronous, active-low. `rst`=0 at a rising edge resets the block.
- `start` input 1: request strobe, sampled only when `busy`=0.
- `pattern` input WIDTH: bits to send, MSB first; latched when `start` is accepted.
- `count` input CNT_W: number of frames; latched when `start` is accepted.
- `gap` input GAP_W: number of zero cycles between frames; latched when `start` is accepted.
- `signal` output 1: serial data, registered.
- `busy` output 1: high while a transfer is in progress, registered.
- `frame_end` output 1: high during the cycle that carries the last bit of each frame, registered.
- `done` output 1: one-cycle pulse after the last frame, registered.

## Operation
- FSM states: IDLE, SEND, GAP, DONE.
- Reset (`rst`=0 at an edge): state=IDLE and all outputs 0 (`signal`, `busy`, `frame_end`, `done`). All internal counters and latched fields are cleared.
- IDLE: `signal`=0, `busy`=0.
  - `start`=1 with `count`≠0: latch `pattern`, `count` and `gap`; set frames_left=`count` and bit_idx=WIDTH-1; go to SEND.
  - `start`=1 with `count`=0: ignored. No `busy` and no `done`.
- SEND: `signal`=pat[bit_idx], `busy`=1. bit_idx decrements each cycle.
  - At bit_idx=0, `frame_end`=1 and frames_left decrements.
  - Then, if frames_left was >1 and gap=0: reload bit_idx=WIDTH-1 and stay in SEND (back-to-back frames).
  - If frames_left was >1 and gap>0: go to GAP with gap_cnt=gap.
  - If frames_left was 1: go to DONE.
- GAP: `signal`=0, `busy`=1, for exactly `gap` cycles. Then go to SEND with bit_idx=WIDTH-1.
- DONE: lasts one cycle with `done`=1, `busy`=0, `signal`=0. Then go to IDLE.
  - `start` is accepted in DONE exactly as in IDLE. The next state is then SEND directly.
- `start` while `busy`=1 is ignored. Changes to `pattern`, `count` or `gap` during a transfer have no effect.
- Counter widths:
  - frames_left is CNT_W bits. `count`=2^CNT_W-1 is legal.
  - gap_cnt is GAP_W bits.
  - bit_idx is $clog2(WIDTH) bits.
  - No wrap-around is allowed in any counter.
- `rst`=0 mid-transfer aborts immediately at that edge. No `done` pulse is produced.

## Timing
- Call the accepting edge of `start` E0. The first bit pat[WIDTH-1] is on `signal` in the cycle after E0, with `busy`=1 in the same cycle.
- Latency from start to first bit: 1 cycle.
- Each bit is held exactly 1 cycle.
- Frame period is WIDTH+gap cycles.
- Total `busy` cycles: count·WIDTH + (count-1)·gap.
- `done` is asserted in the cycle immediately after the last `frame_end` cycle.
- `frame_end` coincides with the bit_idx=0 cycle of every frame.

## Structure
- Shared package `seq_gen_pkg` holds:
  - the state enum (IDLE, SEND, GAP, DONE);
  - default WIDTH/CNT_W/GAP_W constants;
  - the canonical pattern constant PAT_1011=4'b1011.
- One natural sub-module, `piso_shift`: a WIDTH-bit parallel-load, MSB-first shift register with load/shift enables. The FSM, frame counter and gap counter stay in `seq_gen`.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `start`=1. Then `signal`, `busy`, `frame_end` and `done` must all be 0, and no transfer may start.
- Single frame: pattern=1011, count=1, gap=0. `signal` must read 1,0,1,1 in cycles 1–4 after E0, `frame_end` only in cycle 4, `done` in cycle 5, `busy` high in cycles 1–4.
- Back-to-back: count=3, gap=0. `signal` must read 101110111011, with 3 `frame_end` pulses and 12 `busy` cycles. A non-overlapping 1011 Mealy detector on `signal` must assert exactly 3 times.
- Gap: pattern=1101, count=2, gap=3. `signal` must read 1101 000 1101 and `busy` must last 11 cycles.
- Ignored requests: (a) count=0 must produce no `busy` and no `done`. (b) A `start` and a new pattern applied mid-transfer must not alter the stream. (c) A `start` in the DONE cycle must make its first bit appear in the next cycle.
- Abort: `rst`=0 in the third bit of a count=2 transfer. Outputs must be 0 in the next cycle with no `done`. A subsequent `start` must operate normally.
